// File: rtl/midori_sbox_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : midori_sbox_serializer_if
// Purpose  : Start/randomness/S-box/result bundle of the Midori S-box serializer
// Revision : 1.0 - initial release
// ============================================================================
interface midori_sbox_serializer_if #(
  parameter int RW = 96
);
  logic          start_valid;
  logic          start_ready;
  logic [63:0]   state_in1;
  logic [63:0]   state_in2;
  logic [63:0]   state_in3;
  logic [RW-1:0] rnd_in;
  logic          rnd_valid;
  logic          rnd_ready;
  logic [3:0]    sb_in1;
  logic [3:0]    sb_in2;
  logic [3:0]    sb_in3;
  logic [7:0]    sb_neigh;
  logic [RW-1:0] sb_r;
  logic [3:0]    sb_out1;
  logic [3:0]    sb_out2;
  logic [3:0]    sb_out3;
  logic          res_valid;
  logic          res_ready;
  logic [63:0]   state_out1;
  logic [63:0]   state_out2;
  logic [63:0]   state_out3;

  modport slave (
    input  start_valid, state_in1, state_in2, state_in3, rnd_in, rnd_valid,
           sb_out1, sb_out2, sb_out3, res_ready,
    output start_ready, rnd_ready, sb_in1, sb_in2, sb_in3, sb_neigh, sb_r,
           res_valid, state_out1, state_out2, state_out3
  );

  modport master (
    output start_valid, state_in1, state_in2, state_in3, rnd_in, rnd_valid,
           sb_out1, sb_out2, sb_out3, res_ready,
    input  start_ready, rnd_ready, sb_in1, sb_in2, sb_in3, sb_neigh, sb_r,
           res_valid, state_out1, state_out2, state_out3
  );
endinterface
`default_nettype wire

// File: rtl/midori_sbox_serializer.sv
`default_nettype none
// ============================================================================
// Module   : midori_sbox_serializer
// Purpose  : Nibble-serial feeder/collector around a 3-share masked Midori S-box
// Revision : 1.0 - initial release
// ============================================================================
module midori_sbox_serializer #(
  parameter int NIB = 16,
  parameter int RW  = 96
) (
  input  logic                     clk,
  input  logic                     rst_i,
  midori_sbox_serializer_if.slave  bus
);
  localparam int c_IW = $clog2(NIB);
  localparam logic [c_IW-1:0] c_ILAST = c_IW'(NIB - 1);
  localparam logic [c_IW:0]   c_CLAST = (c_IW + 1)'(NIB - 1);
  localparam logic [c_IW:0]   c_CFULL = (c_IW + 1)'(NIB);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state, w_state_nx;
  logic [4*NIB-1:0]  r_sh1, r_sh2, r_sh3;
  logic [4*NIB-1:0]  r_res1, r_res2, r_res3;
  logic [c_IW-1:0]   r_issue_cnt;
  logic [c_IW:0]     r_cap_cnt;
  logic              r_issued_d;
  logic              w_issue;
  logic              w_start_hs;
  logic [c_IW-1:0]   w_nb_idx;

  assign w_start_hs = (r_state == S_IDLE) && bus.start_valid;
  assign w_nb_idx   = r_issue_cnt + 1'b1;   // wraps 15 -> 0

  assign bus.state_out1 = r_res1;
  assign bus.state_out2 = r_res2;
  assign bus.state_out3 = r_res3;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_sh1       <= '0;
      r_sh2       <= '0;
      r_sh3       <= '0;
      r_res1      <= '0;
      r_res2      <= '0;
      r_res3      <= '0;
      r_issue_cnt <= '0;
      r_cap_cnt   <= '0;
      r_issued_d  <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_issued_d <= w_issue;
      if (w_start_hs) begin
        r_sh1       <= bus.state_in1;
        r_sh2       <= bus.state_in2;
        r_sh3       <= bus.state_in3;
        r_issue_cnt <= '0;
        r_cap_cnt   <= '0;
      end else begin
        if (w_issue)
          r_issue_cnt <= r_issue_cnt + 1'b1;
        // The S-box pipeline cannot stall, so capture follows the issue by exactly one cycle
        if (r_issued_d && (r_cap_cnt != c_CFULL)) begin
          r_res1[4*r_cap_cnt[c_IW-1:0] +: 4] <= bus.sb_out1;
          r_res2[4*r_cap_cnt[c_IW-1:0] +: 4] <= bus.sb_out2;
          r_res3[4*r_cap_cnt[c_IW-1:0] +: 4] <= bus.sb_out3;
          r_cap_cnt <= r_cap_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_state_nx      = r_state;
    w_issue         = 1'b0;
    bus.start_ready = 1'b0;
    bus.rnd_ready   = 1'b0;
    bus.res_valid   = 1'b0;
    bus.sb_in1      = 4'h0;
    bus.sb_in2      = 4'h0;
    bus.sb_in3      = 4'h0;
    bus.sb_neigh    = 8'h00;
    bus.sb_r        = {RW{1'b0}};
    case (r_state)
      S_IDLE: begin
        bus.start_ready = 1'b1;
        if (bus.start_valid)
          w_state_nx = S_RUN;
      end
      S_RUN: begin
        // Data goes out only alongside fresh randomness; otherwise the S-box sees zeros
        w_issue       = bus.rnd_valid;
        bus.rnd_ready = bus.rnd_valid;
        if (w_issue) begin
          bus.sb_in1   = r_sh1[4*r_issue_cnt +: 4];
          bus.sb_in2   = r_sh2[4*r_issue_cnt +: 4];
          bus.sb_in3   = r_sh3[4*r_issue_cnt +: 4];
          bus.sb_neigh = {r_sh2[4*w_nb_idx +: 4], r_sh1[4*w_nb_idx +: 4]};
          bus.sb_r     = bus.rnd_in;
          if (r_issue_cnt == c_ILAST)
            w_state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((r_cap_cnt == c_CFULL) || (r_issued_d && (r_cap_cnt == c_CLAST)))
          w_state_nx = S_DONE;
      end
      S_DONE: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready)
          w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end
endmodule
`default_nettype wire

// File: tb/tb_midori_sbox_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_midori_sbox_serializer
// Purpose  : Directed self-checking bench with a behavioural 3-share S-box
// Revision : 1.0 - initial release
// ============================================================================
module tb_midori_sbox_serializer;
  localparam int RW = 96;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  midori_sbox_serializer_if #(.RW(RW)) bus ();

  midori_sbox_serializer #(.NIB(16), .RW(RW)) dut (
    .clk   (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  logic [7:0] neigh_log [0:63];
  logic [3:0] in1_log   [0:63];

  function automatic logic [3:0] sb0(input logic [3:0] x);
    case (x)
      4'h0: sb0 = 4'hC; 4'h1: sb0 = 4'hA; 4'h2: sb0 = 4'hD; 4'h3: sb0 = 4'h3;
      4'h4: sb0 = 4'hE; 4'h5: sb0 = 4'hB; 4'h6: sb0 = 4'hF; 4'h7: sb0 = 4'h7;
      4'h8: sb0 = 4'h8; 4'h9: sb0 = 4'h9; 4'hA: sb0 = 4'h1; 4'hB: sb0 = 4'h5;
      4'hC: sb0 = 4'h0; 4'hD: sb0 = 4'h2; 4'hE: sb0 = 4'h4; default: sb0 = 4'h6;
    endcase
  endfunction

  // One-cycle registered masked S-box model: shares 2/3 come from the randomness
  always @(posedge clk) begin
    bus.sb_out2 <= bus.sb_r[3:0];
    bus.sb_out3 <= bus.sb_r[7:4];
    bus.sb_out1 <= sb0(bus.sb_in1 ^ bus.sb_in2 ^ bus.sb_in3) ^ bus.sb_r[3:0] ^ bus.sb_r[7:4];
  end

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Handshake at cycle 0, then step cycles until res_valid or the budget runs out
  task automatic run(input logic [63:0] x, input logic [63:0] s2, input logic [63:0] s3,
                     input logic [63:0] stall, input int pulse,
                     output int lat, output int rr);
    lat = -1;
    rr  = 0;
    bus.state_in1   = x ^ s2 ^ s3;
    bus.state_in2   = s2;
    bus.state_in3   = s3;
    bus.start_valid = 1'b1;
    bus.rnd_valid   = 1'b0;
    #1;
    chk("start_ready_idle", bus.start_ready, 1);
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    for (int c = 1; c < 60; c++) begin
      bus.rnd_valid = !stall[c];
      bus.rnd_in    = {$urandom, $urandom, $urandom};
      if (c == pulse) begin
        bus.start_valid = 1'b1;
        bus.state_in1   = ~bus.state_in1;
      end else begin
        bus.start_valid = 1'b0;
      end
      #1;
      if (bus.rnd_ready) rr++;
      neigh_log[c] = bus.sb_neigh;
      in1_log[c]   = bus.sb_in1;
      if (stall[c])
        chk("stall_quiet", {bus.sb_in1, bus.sb_in2, bus.sb_in3, bus.sb_neigh, bus.sb_r, bus.rnd_ready}, 0);
      if (bus.res_valid) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    bus.start_valid = 1'b0;
    bus.rnd_valid   = 1'b0;
  endtask

  function automatic logic [63:0] unmask();
    return bus.state_out1 ^ bus.state_out2 ^ bus.state_out3;
  endfunction

  initial begin
    int lat, rr;
    logic [63:0] s2, s3, h1, h2, h3;
    bus.start_valid = 1'b0;
    bus.state_in1   = '0;
    bus.state_in2   = '0;
    bus.state_in3   = '0;
    bus.rnd_in      = '0;
    bus.rnd_valid   = 1'b0;
    bus.res_ready   = 1'b1;

    // Reset state
    #12;
    chk("rst_start_ready", bus.start_ready, 1);
    chk("rst_rnd_ready", bus.rnd_ready, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_sb_outs", {bus.sb_in1, bus.sb_in2, bus.sb_in3, bus.sb_neigh, bus.sb_r}, 0);
    chk("rst_state_out", {bus.state_out1, bus.state_out2, bus.state_out3}, 0);
    @(negedge clk); rst_i = 1'b0;
    @(posedge clk); #1;

    // Basic run
    s2 = {$urandom, $urandom};
    s3 = {$urandom, $urandom};
    run(64'h0123456789ABCDEF, s2, s3, 64'h0, 0, lat, rr);
    chk("basic_latency", lat, 18);
    chk("basic_rnd_ready_cnt", rr, 16);
    chk("basic_result", unmask(), 64'hCAD3EBF789150246);
    @(posedge clk); #1;
    chk("basic_back_idle", {bus.start_ready, bus.res_valid}, 2'b10);

    // Randomness stalls in cycles 3, 4, 10
    s2 = {$urandom, $urandom};
    s3 = {$urandom, $urandom};
    run(64'h0123456789ABCDEF, s2, s3, 64'h418, 0, lat, rr);
    chk("stall_latency", lat, 21);
    chk("stall_rnd_ready_cnt", rr, 16);
    chk("stall_result", unmask(), 64'hCAD3EBF789150246);
    @(posedge clk); #1;

    // Neighbour selection and wrap: share1 = 0x13, share2 = 0x07
    run(64'h14, 64'h07, 64'h0, 64'h0, 0, lat, rr);
    chk("neigh_latency", lat, 18);
    chk("neigh_nib0", neigh_log[1], 8'h01);
    chk("sb_in1_nib0", in1_log[1], 4'h3);
    chk("neigh_nib15_wrap", neigh_log[16], 8'h73);
    chk("neigh_result", unmask(), 64'hCCCCCCCCCCCCCCAE);
    @(posedge clk); #1;

    // Back-pressure in DONE
    bus.res_ready = 1'b0;
    s2 = {$urandom, $urandom};
    s3 = {$urandom, $urandom};
    run(64'hFEDCBA9876543210, s2, s3, 64'h0, 0, lat, rr);
    chk("bp_latency", lat, 18);
    h1 = bus.state_out1; h2 = bus.state_out2; h3 = bus.state_out3;
    for (int k = 0; k < 5; k++) begin
      bus.start_valid = 1'b1;
      @(posedge clk); #1;
      chk("bp_hold_outputs", {bus.state_out1, bus.state_out2, bus.state_out3}, {h1, h2, h3});
      chk("bp_flags", {bus.res_valid, bus.start_ready}, 2'b10);
    end
    bus.start_valid = 1'b0;
    chk("bp_result", unmask(), 64'h642051987FBE3DAC);
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_released", {bus.res_valid, bus.start_ready}, 2'b01);

    // Asynchronous reset mid-RUN (cycle 8)
    bus.state_in1   = 64'h0123456789ABCDEF;
    bus.state_in2   = 64'h0;
    bus.state_in3   = 64'h0;
    bus.start_valid = 1'b1;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    bus.rnd_valid   = 1'b1;
    for (int c = 1; c < 8; c++) begin
      bus.rnd_in = {$urandom, $urandom, $urandom};
      @(posedge clk); #1;
    end
    #2 rst_i = 1'b1;
    #1;
    chk("arst_sb_outs", {bus.sb_in1, bus.sb_in2, bus.sb_in3, bus.sb_neigh, bus.sb_r}, 0);
    chk("arst_flags", {bus.rnd_ready, bus.res_valid, bus.start_ready}, 3'b001);
    chk("arst_state_out", {bus.state_out1, bus.state_out2, bus.state_out3}, 0);
    bus.rnd_valid = 1'b0;
    @(negedge clk); rst_i = 1'b0;
    @(posedge clk); #1;
    chk("arst_start_ready", bus.start_ready, 1);

    // Fresh run after reset, with a start pulse during RUN that must be ignored
    s2 = {$urandom, $urandom};
    s3 = {$urandom, $urandom};
    run(64'hFEDCBA9876543210, s2, s3, 64'h0, 5, lat, rr);
    chk("fresh_latency", lat, 18);
    chk("fresh_result", unmask(), 64'h642051987FBE3DAC);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire

// File: doc/midori_sbox_serializer.md
Name: midori_sbox_serializer

Overview:
- Serial feeder and collector for one second-order masked Midori S-box instance (3 shares, 96-bit fresh randomness per evaluation, 1-cycle registered latency).
- Accepts a full 64-bit three-share state, issues one nibble per cycle to the S-box with its neighbouring-nibble shares and fresh randomness, then reassembles the 3-share substituted state.
- Sits between the round datapath (MixColumn/key-add) and the masked S-box. Handles randomness stalls around the S-box's fixed, non-stallable pipeline.

Parameters:
- NIB, 16, nibbles per state. 64-bit state, fixed for Midori64.
- RW, 96, randomness bits consumed per S-box evaluation.

Ports:
- clk  in  1  system clock, rising edge
- rst_i  in  1  asynchronous active-high reset
- start_valid  in  1  input state offered
- start_ready  out  1  block idle, state accepted when start_valid & start_ready
- state_in1 / state_in2 / state_in3  in  64 each  input shares; nibble i = bits [4i+3:4i]
- rnd_in  in  RW  fresh randomness from PRNG
- rnd_valid  in  1  rnd_in is fresh
- rnd_ready  out  1  rnd_in consumed this cycle
- sb_in1 / sb_in2 / sb_in3  out  4 each  S-box input shares
- sb_neigh  out  8  neighbouring-S-box shares to S-box
- sb_r  out  RW  randomness to S-box
- sb_out1 / sb_out2 / sb_out3  in  4 each  S-box output shares, valid one cycle after the inputs are issued
- res_valid  out  1  result state available
- res_ready  in  1  consumer accepts result
- state_out1 / state_out2 / state_out3  out  64 each  substituted shares

Behaviour:
- Clock is clk. Reset rst_i is asynchronous and active-high.
- Reset: FSM=IDLE, counters=0, issued_d=0, start_ready=1, rnd_ready=0, res_valid=0, and all sb_* outputs, state_out* and internal share registers = 0.
- FSM states are IDLE, RUN, DRAIN, DONE.
  - IDLE: start_ready=1. On handshake, latch the three input shares, issue_cnt=0, cap_cnt=0, go to RUN.
  - RUN: issue = rnd_valid. rnd_ready = issue, combinational from rnd_valid while in RUN, 0 in every other state.
    - When issue=1: sb_inK = shareK nibble issue_cnt; sb_neigh = {share2, share1} of nibble (issue_cnt+1) mod 16 from the latched input state; sb_r = rnd_in; issue_cnt increments.
    - When issue=0: sb_in*, sb_neigh and sb_r are all driven 0. Randomness is never reused and real data is never issued with stale randomness.
    - Go to DRAIN after the issue with issue_cnt=15.
  - DRAIN: sb_* driven 0. Go to DONE when cap_cnt reaches 16.
  - DONE: res_valid=1. state_out* hold stable until res_ready. On the res_valid & res_ready handshake, go to IDLE.
- Issue and capture:
  - issued_d is a register equal to the previous cycle's issue.
  - When issued_d=1, sb_outK is written into the result shareK nibble cap_cnt, and cap_cnt increments.
  - Capture continues in any state until cap_cnt=16, so the last capture happens in DRAIN.
- Latency with rnd_valid held high:
  - Handshake at cycle 0; issues in cycles 1–16; captures at the clock edges closing cycles 2–17; res_valid high from cycle 18.
  - Each deasserted-rnd_valid cycle in RUN adds exactly one cycle.
- Counter wrap: the neighbour index for nibble 15 wraps to nibble 0.
- start_valid outside IDLE is ignored, since start_ready=0. res_ready outside DONE is ignored.
- Reset asserted mid-run discards all state immediately. No partial result is ever flagged valid.
- The result is a correct sharing: XOR of the out shares equals Sb0 of the XOR of the in shares, nibble-wise. Sb0 = C,A,D,3,E,B,F,7,8,9,1,5,0,2,4,6.

Test Plan:
- Basic run: unmasked 0x0123456789ABCDEF (shares 2,3 random, share1 = x ^ s2 ^ s3), rnd_valid=1, res_ready=1 -> res_valid at cycle 18; XOR of out shares = 0xCAD3EBF789150246; rnd_ready high exactly 16 cycles.
- Randomness stalls: same input, rnd_valid low in cycles 3, 4 and 10 -> res_valid at cycle 21; same result; sb_r and sb_in* = 0 in the stall cycles; no capture the following cycle.
- Neighbour check: state_in1 = 0x0000000000000010, others 0 -> sb_neigh = 0x01 when nibble 0 is issued; for nibble 15, sb_neigh = {state_in2 nibble 0, state_in1 nibble 0}.
- Back-pressure: res_ready low for 5 cycles in DONE -> state_out* stable, start_ready=0; new start accepted only after the result handshake.
- Async reset: assert rst_i at cycle 8, mid-RUN -> all outputs 0 immediately; start_ready=1 after release; a fresh start completes correctly.
- Start ignored: start_valid pulsed during RUN -> no effect on the in-flight result.
